retire_unit: RTL

- In-order commit stage; reads the oldest EXT_COUNT ROB slots each cycle and retires the longest contiguous valid prefix.
- Drives the ROB consume and flush interfaces.
- Produces registered architectural register-file writes and a PC redirect on branch mispredict.
- Sits between rob and the register file / fetch unit.

---
 rtl/retire_unit_pkg.sv | 19 +
 rtl/retire_unit_if.sv | 29 ++
 rtl/retire_unit_select.sv | 71 +++++++
 rtl/retire_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/retire_unit_pkg.sv
// Shared types for the in-order commit stage: ROB entry layout and retire FSM states.
package retire_unit_pkg;

    typedef struct packed {
        logic        dest_reg_valid;
        logic [4:0]  dest_reg;
        logic [31:0] result_lo;
        logic        mispredict;
        logic [31:0] target_pc;
        logic        halt;
    } rob_entry_t;

    typedef enum logic [1:0] {
        RUN,
        BDS_WAIT,
        HALT
    } retire_state_t;

endpackage

// File: rtl/retire_unit_if.sv
// ROB <-> retire handshake: head slots in, consume/flush back to the ROB.
interface retire_unit_if #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned EXT_COUNT = 4
);
    import retire_unit_pkg::*;

    localparam int unsigned DEPTHLOG2    = $clog2(DEPTH);
    localparam int unsigned EXTCOUNTLOG2 = $clog2(EXT_COUNT);

    rob_entry_t [EXT_COUNT-1:0] slot_data;
    logic [EXT_COUNT-1:0]       slot_valid;
    logic                       rob_empty;
    logic                       consume;
    logic [EXTCOUNTLOG2-1:0]    consume_count;
    logic                       flush;
    logic [DEPTHLOG2-1:0]       flush_idx;

    modport master (
        output slot_data, slot_valid, rob_empty,
        input  consume, consume_count, flush, flush_idx
    );

    modport slave (
        input  slot_data, slot_valid, rob_empty,
        output consume, consume_count, flush, flush_idx
    );

endinterface

// File: rtl/retire_unit_select.sv
// Combinational retire-group selection: prefix length, truncation slot and
// per-slot regfile write enables with same-register suppression.
module retire_select
    import retire_unit_pkg::*;
#(
    parameter int unsigned EXT_COUNT = 4,
    parameter int unsigned IDXW      = $clog2(EXT_COUNT)
) (
    input  rob_entry_t [EXT_COUNT-1:0] slot_data,
    input  logic [EXT_COUNT-1:0]       slot_valid,
    input  logic                       rob_empty,
    input  logic                       active,
    input  logic                       bds_mode,
    output logic [IDXW:0]              n,
    output logic [IDXW-1:0]            last_idx,
    output logic                       mispredict,
    output logic                       halt,
    output logic [31:0]                target_pc,
    output logic [EXT_COUNT-1:0]       wr_mask
);
    localparam int unsigned CW = IDXW + 1;

    logic                 stop;
    logic [EXT_COUNT-1:0] raw_en;

    always_comb begin
        n          = '0;
        last_idx   = '0;
        mispredict = 1'b0;
        halt       = 1'b0;
        target_pc  = '0;
        stop       = 1'b0;
        for (int unsigned i = 0; i < EXT_COUNT; i++) begin
            if (!stop) begin
                if (active && !rob_empty && slot_valid[i] && (!bds_mode || i == 0)) begin
                    n        = CW'(i + 1);
                    last_idx = IDXW'(i);
                    // The delay slot never re-triggers a redirect.
                    if (slot_data[i].mispredict && !bds_mode) begin
                        mispredict = 1'b1;
                        target_pc  = slot_data[i].target_pc;
                        stop       = 1'b1;
                    end
                    if (slot_data[i].halt) begin
                        halt = 1'b1;
                        stop = 1'b1;
                    end
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

    always_comb begin
        raw_en = '0;
        for (int unsigned i = 0; i < EXT_COUNT; i++) begin
            raw_en[i] = (i < 32'(n)) && slot_data[i].dest_reg_valid && (slot_data[i].dest_reg != '0);
        end
        wr_mask = raw_en;
        // Youngest writer of a register wins; older ones in the group are dropped.
        for (int unsigned i = 0; i < EXT_COUNT; i++) begin
            for (int unsigned k = i + 1; k < EXT_COUNT; k++) begin
                if (raw_en[k] && slot_data[k].dest_reg == slot_data[i].dest_reg) begin
                    wr_mask[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/retire_unit.sv
// In-order commit stage: retires the valid ROB head prefix, flushes on mispredict,
// halts on halt. Optional performance counters under `RETIRE_PERF_EN.
module retire_unit
    import retire_unit_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned EXT_COUNT    = 4,
    parameter int unsigned DEPTHLOG2    = $clog2(DEPTH),
    parameter int unsigned EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
    input  logic                       clock,
    input  logic                       reset,
    retire_unit_if.slave               rob,
    output logic                       redirect_valid,
    output logic [31:0]                redirect_pc,
    output logic [EXT_COUNT-1:0]       rf_wr_en,
    output logic [EXT_COUNT-1:0][4:0]  rf_wr_addr,
    output logic [EXT_COUNT-1:0][31:0] rf_wr_data,
    output logic                       halted,
    output logic [31:0]                perf_retired,
    output logic [15:0]                perf_flushes
);
    retire_state_t             state, state_next;
    logic [DEPTHLOG2-1:0]      head_idx;
    logic [EXTCOUNTLOG2:0]     n;
    logic [EXTCOUNTLOG2-1:0]   last_idx;
    logic                      sel_mispredict, sel_halt;
    logic [31:0]               sel_target;
    logic [EXT_COUNT-1:0]      wr_mask;
    logic                      sel_active, sel_bds;

    assign sel_active = (state != HALT);
    assign sel_bds    = (state == BDS_WAIT);

    retire_select #(.EXT_COUNT(EXT_COUNT)) u_select (
        .slot_data  (rob.slot_data),
        .slot_valid (rob.slot_valid),
        .rob_empty  (rob.rob_empty),
        .active     (sel_active),
        .bds_mode   (sel_bds),
        .n          (n),
        .last_idx   (last_idx),
        .mispredict (sel_mispredict),
        .halt       (sel_halt),
        .target_pc  (sel_target),
        .wr_mask    (wr_mask)
    );

    always_comb begin
        state_next        = state;
        rob.consume       = (n != '0);
        rob.consume_count = EXTCOUNTLOG2'(n - 1'b1);
        rob.flush         = sel_mispredict;
        rob.flush_idx     = head_idx + DEPTHLOG2'(last_idx);
        case (state)
            RUN: begin
                if (sel_halt)            state_next = HALT;
                else if (sel_mispredict) state_next = BDS_WAIT;
            end
            BDS_WAIT: begin
                if (n != '0) state_next = sel_halt ? HALT : RUN;
            end
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    assign halted = (state == HALT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= RUN;
            head_idx       <= '0;
            rf_wr_en       <= '0;
            rf_wr_addr     <= '0;
            rf_wr_data     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_next;
            head_idx       <= head_idx + DEPTHLOG2'(n);
            rf_wr_en       <= wr_mask;
            redirect_valid <= sel_mispredict;
            if (sel_mispredict) redirect_pc <= sel_target;
            for (int unsigned i = 0; i < EXT_COUNT; i++) begin
                rf_wr_addr[i] <= rob.slot_data[i].dest_reg;
                rf_wr_data[i] <= rob.slot_data[i].result_lo;
            end
        end
    end

`ifdef RETIRE_PERF_EN
    logic [31:0] retired_q;
    logic [15:0] flushes_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            retired_q <= '0;
            flushes_q <= '0;
        end else begin
            retired_q <= retired_q + 32'(n);
            flushes_q <= flushes_q + 16'(sel_mispredict);
        end
    end

    assign perf_retired = retired_q;
    assign perf_flushes = flushes_q;
`else
    assign perf_retired = '0;
    assign perf_flushes = '0;
`endif

endmodule
